// File: rtl/rob_ring.sv
// In-order-commit reorder buffer: allocates tagged entries at dispatch, accepts
// out-of-order completions by tag, and retires completed entries from the head.
module rob_ring #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int TAG_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic [INSTR_W-1:0] alloc_instr,
  input  logic [REG_W-1:0]   alloc_dest,
  output logic [TAG_W-1:0]   alloc_tag,
  input  logic               cmpl_valid,
  input  logic [TAG_W-1:0]   cmpl_tag,
  input  logic [DATA_W-1:0]  cmpl_value,
  output logic               commit_valid,
  input  logic               commit_ready,
  output logic [TAG_W-1:0]   commit_tag,
  output logic [INSTR_W-1:0] commit_instr,
  output logic [REG_W-1:0]   commit_dest,
  output logic [DATA_W-1:0]  commit_value,
  input  logic               flush,
  output logic [TAG_W:0]     count,
  output logic               empty,
  output logic               full
);

  logic [TAG_W:0]     head, tail;
  logic [TAG_W-1:0]   head_idx, tail_idx;
  logic [DEPTH-1:0]   valid_q, done_q;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [REG_W-1:0]   dest_mem  [DEPTH];
  logic [DATA_W-1:0]  value_mem [DEPTH];
  logic               alloc_fire, commit_fire, cmpl_hit;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count = tail - head;
  assign empty = (head == tail);
  assign full  = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

  assign alloc_ready  = !full;
  assign alloc_tag    = tail_idx;
  assign commit_valid = !empty && done_q[head_idx];
  assign commit_tag   = head_idx;
  assign commit_instr = instr_mem[head_idx];
  assign commit_dest  = dest_mem[head_idx];
  assign commit_value = value_mem[head_idx];

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = commit_valid && commit_ready;
  assign cmpl_hit    = cmpl_valid && valid_q[cmpl_tag];

  // Control state. The tail slot is never valid unless full, so an alloc and a
  // completion hit can never target the same entry; commit is ordered after
  // completion so a same-cycle completion of the retiring head leaves it clear.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (cmpl_hit) begin
        done_q[cmpl_tag] <= 1'b1;
      end
      if (commit_fire) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head              <= head + (TAG_W+1)'(1);
      end
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail              <= tail + (TAG_W+1)'(1);
      end
    end
  end

  // Payload storage; contents are only observed through valid/done entries.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      instr_mem[tail_idx] <= alloc_instr;
      dest_mem[tail_idx]  <= alloc_dest;
    end
    if (cmpl_hit) begin
      value_mem[cmpl_tag] <= cmpl_value;
    end
  end

endmodule

// File: tb/tb_rob_ring.sv
// Self-checking bench for rob_ring: directed scenarios plus randomized traffic
// compared every cycle against an unbounded-sequence-number model.
module tb_rob_ring;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n, alloc_valid, alloc_ready, cmpl_valid, commit_valid, commit_ready, flush;
  logic [15:0] alloc_instr, cmpl_value, commit_instr, commit_value;
  logic [2:0]  alloc_dest, commit_dest;
  logic [3:0]  alloc_tag, cmpl_tag, commit_tag;
  logic [4:0]  count;
  logic        empty, full;

  rob_ring dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_instr(alloc_instr),
    .alloc_dest(alloc_dest), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_value(cmpl_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .commit_instr(commit_instr), .commit_dest(commit_dest), .commit_value(commit_value),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: entries addressed by sequence number; tag = seq mod DEPTH.
  int          m_head = 0, m_tail = 0;
  bit          m_valid [D];
  bit          m_done  [D];
  logic [15:0] m_instr [D];
  logic [2:0]  m_dest  [D];
  logic [15:0] m_value [D];
  bit          m_af, m_cf;

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      m_head = 0;
      m_tail = 0;
      for (int i = 0; i < D; i++) begin
        m_valid[i] = 1'b0;
        m_done[i]  = 1'b0;
      end
    end else begin
      m_cf = (m_tail != m_head) && m_done[m_head % D] && commit_ready;
      m_af = alloc_valid && (m_tail - m_head < D);
      if (cmpl_valid && m_valid[cmpl_tag]) begin
        m_done[cmpl_tag]  = 1'b1;
        m_value[cmpl_tag] = cmpl_value;
      end
      if (m_cf) begin
        m_valid[m_head % D] = 1'b0;
        m_done[m_head % D]  = 1'b0;
        m_head++;
      end
      if (m_af) begin
        m_valid[m_tail % D] = 1'b1;
        m_done[m_tail % D]  = 1'b0;
        m_instr[m_tail % D] = alloc_instr;
        m_dest[m_tail % D]  = alloc_dest;
        m_tail++;
      end
    end
  end

  int hx, occ;
  bit cv;
  always @(negedge clk) begin
    if (chk_en) begin
      hx  = m_head % D;
      occ = m_tail - m_head;
      cv  = (occ != 0) && m_done[hx];
      chk("count", 32'(count), 32'(occ));
      chk("empty", 32'(empty), 32'(occ == 0));
      chk("full", 32'(full), 32'(occ == D));
      chk("alloc_ready", 32'(alloc_ready), 32'(occ != D));
      chk("alloc_tag", 32'(alloc_tag), 32'(m_tail % D));
      chk("commit_valid", 32'(commit_valid), 32'(cv));
      chk("commit_tag", 32'(commit_tag), 32'(hx));
      if (cv) begin
        chk("commit_instr", 32'(commit_instr), 32'(m_instr[hx]));
        chk("commit_dest", 32'(commit_dest), 32'(m_dest[hx]));
        chk("commit_value", 32'(commit_value), 32'(m_value[hx]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 1'b0; cmpl_valid = 1'b0; commit_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      alloc_instr = 16'h1000 + 16'(i);
      alloc_dest  = 3'(i);
      cyc();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [3:0] t, input logic [15:0] v);
    cmpl_valid = 1'b1; cmpl_tag = t; cmpl_value = v;
    cyc();
    cmpl_valid = 1'b0;
  endtask

  initial begin
    alloc_instr = '0; alloc_dest = '0; cmpl_tag = '0; cmpl_value = '0;
    idle();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst count", 32'(count), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst alloc_ready", 32'(alloc_ready), 1);
    chk("rst commit_valid", 32'(commit_valid), 0);
    chk("rst tags", {alloc_tag, commit_tag}, 0);

    // Basic allocation and head completion
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_instr = 16'h2000 + 16'(i); alloc_dest = 3'(i);
      chk("t1 alloc_tag", 32'(alloc_tag), 32'(i));
      cyc();
    end
    alloc_valid = 1'b0;
    chk("t1 count", 32'(count), 3);
    chk("t1 commit_valid0", 32'(commit_valid), 0);
    complete(4'd0, 16'hABCD);
    chk("t1 commit_valid1", 32'(commit_valid), 1);
    chk("t1 commit_value", 32'(commit_value), 32'h0000ABCD);

    // Out-of-order completion, in-order retirement
    do_reset();
    alloc_n(3);
    complete(4'd2, 16'h0022);
    complete(4'd1, 16'h0011);
    chk("t2 commit_valid0", 32'(commit_valid), 0);
    commit_ready = 1'b1;
    complete(4'd0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      chk("t2 commit_tag", 32'(commit_tag), 32'(i));
      chk("t2 commit_valid", 32'(commit_valid), 1);
      cyc();
    end
    commit_ready = 1'b0;
    chk("t2 empty", 32'(empty), 1);

    // Full, refused alloc, wrap
    do_reset();
    alloc_n(16);
    chk("t3 full", 32'(full), 1);
    chk("t3 alloc_ready", 32'(alloc_ready), 0);
    chk("t3 count16", 32'(count), 16);
    alloc_valid = 1'b1; cyc(); alloc_valid = 1'b0;
    chk("t3 refused", 32'(count), 16);
    complete(4'd0, 16'h1234);
    commit_ready = 1'b1; cyc(); commit_ready = 1'b0;
    chk("t3 ready after commit", 32'(alloc_ready), 1);
    chk("t3 count15", 32'(count), 15);
    chk("t3 wrap tag", 32'(alloc_tag), 0);
    alloc_n(1);
    chk("t3 full again", 32'(full), 1);

    // Backpressure
    do_reset();
    alloc_n(2);
    complete(4'd0, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      chk("t4 stall valid", 32'(commit_valid), 1);
      chk("t4 stall value", 32'(commit_value), 32'h0000BEEF);
      chk("t4 stall count", 32'(count), 2);
      cyc();
    end
    commit_ready = 1'b1; cyc(); commit_ready = 1'b0;
    chk("t4 one commit", 32'(count), 1);
    chk("t4 next not done", 32'(commit_valid), 0);

    // Simultaneous alloc + commit + completion, stray completion
    do_reset();
    alloc_n(5);
    complete(4'd0, 16'h0F0F);
    alloc_valid = 1'b1; commit_ready = 1'b1;
    complete(4'd3, 16'h5555);
    idle();
    chk("t5 count", 32'(count), 5);
    complete(4'd12, 16'h9999);
    chk("t5 stray count", 32'(count), 5);
    complete(4'd1, 16'h0001);
    complete(4'd2, 16'h0002);
    commit_ready = 1'b1;
    cyc(); cyc();
    chk("t5 tag3 valid", 32'(commit_valid), 1);
    chk("t5 tag3 tag", 32'(commit_tag), 3);
    chk("t5 tag3 value", 32'(commit_value), 32'h00005555);
    commit_ready = 1'b0;

    // Flush and mid-operation reset
    do_reset();
    alloc_n(7);
    alloc_valid = 1'b1; flush = 1'b1; cyc(); idle();
    chk("t6 flush count", 32'(count), 0);
    chk("t6 flush empty", 32'(empty), 1);
    chk("t6 flush tag", 32'(alloc_tag), 0);
    alloc_n(7);
    alloc_valid = 1'b1; rst_n = 1'b0; cyc(); rst_n = 1'b1; idle();
    chk("t6 rst count", 32'(count), 0);
    chk("t6 rst empty", 32'(empty), 1);
    chk("t6 rst tag", 32'(alloc_tag), 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      alloc_valid  = ($urandom_range(0, 99) < 55);
      alloc_instr  = 16'($urandom);
      alloc_dest   = 3'($urandom);
      cmpl_valid   = ($urandom_range(0, 99) < 60);
      cmpl_tag     = 4'($urandom);
      cmpl_value   = 16'($urandom);
      commit_ready = ($urandom_range(0, 99) < 70);
      flush        = ($urandom_range(0, 149) == 0);
      rst_n        = ($urandom_range(0, 399) != 0);
      cyc();
    end
    rst_n = 1'b1;
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
